// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the banked data memory.
// Holds the sweep FSM state encoding, the fixed read latency and a
// parameter-legality helper used for elaboration-time checks.
package dmem_pkg;

    typedef enum logic {CLEAR, READY} dmem_state_e;

    localparam int DMEM_READ_LATENCY = 1;

    // Word width must be whole bytes; depth must fit the address space.
    function automatic bit dmem_params_ok(input int data_width, input int address_line, input int mem_size);
        return data_width > 0 && data_width % 8 == 0 && mem_size >= 2 &&
               longint'(mem_size) <= (longint'(1) << address_line);
    endfunction

endpackage

// File: rtl/data_memory_banked_if.sv
// data_memory_banked_if: request/response bus of the data memory.
// master: req_valid, req_write, address, write_data, byte_en out; req_ready, rsp_valid, read_data, addr_error in.
// slave:  the mirror image.
interface data_memory_banked_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_LINE = 8
);
    localparam int BYTE_LANES = DATA_WIDTH / 8;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDRESS_LINE-1:0] address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [BYTE_LANES-1:0]   byte_en;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    addr_error;

    modport master (
        output req_valid, req_write, address, write_data, byte_en,
        input  req_ready, rsp_valid, read_data, addr_error
    );

    modport slave (
        input  req_valid, req_write, address, write_data, byte_en,
        output req_ready, rsp_valid, read_data, addr_error
    );

endinterface

// File: rtl/dmem_clear_fsm.sv
// dmem_clear_fsm: zeroing sweep controller for the data memory.
// Ports: clock, reset (async active-low), clear (restart sweep),
//        sweep_we/sweep_addr (one zero-write per cycle while clearing),
//        init_done (high in READY).
module dmem_clear_fsm
    import dmem_pkg::*;
#(
    parameter int MEM_SIZE = 256,
    parameter int PTR_W    = $clog2(MEM_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    output logic             sweep_we,
    output logic [PTR_W-1:0] sweep_addr,
    output logic             init_done
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(MEM_SIZE - 1);

    dmem_state_e      state;
    logic [PTR_W-1:0] clr_ptr;

    assign sweep_we   = state == CLEAR;
    assign sweep_addr = clr_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            if (clear) begin
                clr_ptr <= '0;
            end else if (clr_ptr == LAST) begin
                state     <= READY;
                init_done <= 1'b1;
                clr_ptr   <= '0;
            end else begin
                clr_ptr <= clr_ptr + PTR_W'(1);
            end
        end else if (clear) begin
            state     <= CLEAR;
            init_done <= 1'b0;
            clr_ptr   <= '0;
        end
    end

endmodule

// File: rtl/data_memory_banked.sv
// data_memory_banked: byte-enabled data memory with 1-cycle registered reads.
// Ports: clock, reset (async active-low), clear (restart zeroing sweep),
//        init_done (memory swept and accepting requests),
//        bus (slave side of data_memory_banked_if: valid/ready request, read response, addr_error).
module data_memory_banked
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_LINE = 8,
    parameter int MEM_SIZE     = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    output logic                 init_done,
    data_memory_banked_if.slave  bus
);

    localparam int BYTE_LANES = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(MEM_SIZE);
    // One extra bit so MEM_SIZE == 2**ADDRESS_LINE is representable.
    localparam logic [ADDRESS_LINE:0] SIZE_LIM = (ADDRESS_LINE + 1)'(MEM_SIZE);

    if (!dmem_params_ok(DATA_WIDTH, ADDRESS_LINE, MEM_SIZE) || DMEM_READ_LATENCY != 1) begin : g_param_check
        $error("data_memory_banked: illegal DATA_WIDTH/ADDRESS_LINE/MEM_SIZE");
    end

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic                  sweep_we;
    logic [PTR_W-1:0]      sweep_addr;
    logic                  accept;
    logic                  in_range;
    logic [PTR_W-1:0]      idx;

    dmem_clear_fsm #(.MEM_SIZE(MEM_SIZE), .PTR_W(PTR_W)) u_clear_fsm (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .init_done  (init_done)
    );

    assign bus.req_ready = init_done;
    assign accept        = bus.req_valid && bus.req_ready;
    assign in_range      = {1'b0, bus.address} < SIZE_LIM;
    assign idx           = bus.address[PTR_W-1:0];

    // Sweep and requests are mutually exclusive: requests only land in READY.
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (accept && bus.req_write && in_range) begin
            for (int i = 0; i < BYTE_LANES; i++)
                if (bus.byte_en[i]) mem[idx][8*i +: 8] <= bus.write_data[8*i +: 8];
        end
    end

    // Read samples the pre-write contents (read-first); out-of-range reads return zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rsp_valid  <= 1'b0;
            bus.read_data  <= '0;
            bus.addr_error <= 1'b0;
        end else begin
            bus.rsp_valid  <= accept && !bus.req_write;
            bus.addr_error <= accept && !in_range;
            if (accept && !bus.req_write) bus.read_data <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed self-checking bench for data_memory_banked (32-bit words, 200 of 256 addresses).
module tb_data_memory_banked;

    localparam int DW = 32;
    localparam int AL = 8;
    localparam int MS = 200;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic init_done;
    int   vectors = 0;
    int   miscompares = 0;

    data_memory_banked_if #(.DATA_WIDTH(DW), .ADDRESS_LINE(AL)) bus ();

    data_memory_banked #(.DATA_WIDTH(DW), .ADDRESS_LINE(AL), .MEM_SIZE(MS)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .init_done (init_done),
        .bus       (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        bus.byte_en    = '0;
    endtask

    task automatic drive(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.address    = a;
        bus.write_data = d;
        bus.byte_en    = be;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(w, a, d, be);
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.req_ready && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        idle();
        drive(1'b0, 8'd0, 32'd0, 4'h0);
        repeat (3) tick();
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", bus.req_ready); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL rst_init_done got %b want 0", init_done); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL rst_read_data got %h want 0", bus.read_data); end
        vectors++; if (bus.addr_error !== 1'b0) begin miscompares++; $display("FAIL rst_addr_error got %b want 0", bus.addr_error); end
        reset = 1'b1;
        wait_ready(n);
        vectors++; if (n !== MS) begin miscompares++; $display("FAIL rst_sweep_len got %0d want %0d", n, MS); end
        vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL rst_init_after got %b want 1", init_done); end
        tick();
        idle();
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL first_read_valid got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL first_read_data got %h want 0", bus.read_data); end
    endtask

    task automatic test_byte_lanes;
        issue(1'b1, 8'd5, 32'hAABBCCDD, 4'b1111);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_no_rsp got %b want 0", bus.rsp_valid); end
        issue(1'b1, 8'd5, 32'h11223344, 4'b0101);
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bl_valid got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'hAA22CC44) begin miscompares++; $display("FAIL bl_data got %h want aa22cc44", bus.read_data); end
        tick();
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bl_pulse got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'hAA22CC44) begin miscompares++; $display("FAIL bl_hold got %h want aa22cc44", bus.read_data); end
        issue(1'b1, 8'd5, 32'h00000000, 4'b0000);
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.read_data !== 32'hAA22CC44) begin miscompares++; $display("FAIL be_zero_noop got %h want aa22cc44", bus.read_data); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 8'd3, 32'h0000005A, 4'b1111);
        issue(1'b0, 8'd3, 32'd0, 4'h0);
        vectors++; if (bus.read_data !== 32'h0000005A) begin miscompares++; $display("FAIL b2b_rd3 got %h want 0000005a", bus.read_data); end
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'hAA22CC44) begin miscompares++; $display("FAIL b2b_rd5 got %h want aa22cc44", bus.read_data); end
    endtask

    task automatic test_addr_error;
        issue(1'b1, 8'd199, 32'h00001234, 4'b1111);
        vectors++; if (bus.addr_error !== 1'b0) begin miscompares++; $display("FAIL err_199_wr got %b want 0", bus.addr_error); end
        issue(1'b1, 8'd210, 32'h000000FF, 4'b1111);
        vectors++; if (bus.addr_error !== 1'b1) begin miscompares++; $display("FAIL err_210_wr got %b want 1", bus.addr_error); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL err_210_wr_rsp got %b want 0", bus.rsp_valid); end
        issue(1'b0, 8'd210, 32'd0, 4'h0);
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL err_210_rd_valid got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL err_210_rd_data got %h want 0", bus.read_data); end
        vectors++; if (bus.addr_error !== 1'b1) begin miscompares++; $display("FAIL err_210_rd_err got %b want 1", bus.addr_error); end
        issue(1'b0, 8'd199, 32'd0, 4'h0);
        vectors++; if (bus.read_data !== 32'h00001234) begin miscompares++; $display("FAIL err_199_rd got %h want 00001234", bus.read_data); end
        vectors++; if (bus.addr_error !== 1'b0) begin miscompares++; $display("FAIL err_199_rd_err got %b want 0", bus.addr_error); end
        issue(1'b0, 8'd200, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.addr_error !== 1'b1) begin miscompares++; $display("FAIL err_200 got %b want 1", bus.addr_error); end
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL err_200_data got %h want 0", bus.read_data); end
        tick();
        vectors++; if (bus.addr_error !== 1'b0) begin miscompares++; $display("FAIL err_pulse got %b want 0", bus.addr_error); end
    endtask

    task automatic test_clear;
        int n;
        clear = 1'b1;
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        clear = 1'b0;
        idle();
        vectors++; if (bus.read_data !== 32'hAA22CC44) begin miscompares++; $display("FAIL clr_same_cycle_rd got %h want aa22cc44", bus.read_data); end
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL clr_ready got %b want 0", bus.req_ready); end
        repeat (50) tick();
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL clr_mid got %b want 0", init_done); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_ready(n);
        vectors++; if (n !== MS) begin miscompares++; $display("FAIL clr_restart_len got %0d want %0d", n, MS); end
        issue(1'b0, 8'd3, 32'd0, 4'h0);
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL clr_rd3 got %h want 0", bus.read_data); end
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL clr_rd5 got %h want 0", bus.read_data); end
        issue(1'b0, 8'd199, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL clr_rd199 got %h want 0", bus.read_data); end
    endtask

    task automatic test_async_reset;
        int n;
        issue(1'b1, 8'd5, 32'h12345678, 4'b1111);
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.read_data !== 32'h12345678) begin miscompares++; $display("FAIL ar_pre got %h want 12345678", bus.read_data); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ar_rsp_valid got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL ar_read_data got %h want 0", bus.read_data); end
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL ar_ready got %b want 0", bus.req_ready); end
        tick();
        reset = 1'b1;
        repeat (20) tick();
        #2 reset = 1'b0;
        #1;
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL ar_mid_sweep got %b want 0", init_done); end
        tick();
        reset = 1'b1;
        wait_ready(n);
        vectors++; if (n !== MS) begin miscompares++; $display("FAIL ar_sweep_len got %0d want %0d", n, MS); end
        issue(1'b0, 8'd5, 32'd0, 4'h0);
        idle();
        vectors++; if (bus.read_data !== 32'd0) begin miscompares++; $display("FAIL ar_rd5 got %h want 0", bus.read_data); end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_addr_error();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
